// File: rtl/mcu_ctrl_seq.sv
// rtl/mcu_ctrl_seq.sv - two-word instruction control sequencer for the accumulator MCU
module mcu_ctrl_seq #(
  parameter int INST_WIDTH  = 8,
  parameter int APSR_WIDTH  = 4,
  parameter int N_BIT       = 3,
  parameter int Z_BIT       = 2,
  parameter int C_BIT       = 1,
  parameter int ALUOP_WIDTH = 3,
  parameter int WAIT_MAX    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [INST_WIDTH-1:0]  imem_data,
  input  logic [APSR_WIDTH-1:0]  apsr,
  input  logic                   ram_ready,
  output logic                   ram_req,
  output logic                   ram_write,
  output logic                   imm_update,
  output logic                   pc_count,
  output logic                   pc_load,
  output logic                   opcode_update,
  output logic [ALUOP_WIDTH-1:0] alu_operation,
  output logic                   acc_update,
  output logic                   psr_update,
  output logic                   illegal_op,
  output logic                   bus_error,
  output logic                   halted
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t          state_q;
  logic [3:0]      opcode_q;
  logic [CW-1:0]   wait_q;

  logic            is_jump;
  logic            is_ram;
  logic            is_illegal;
  logic            jump_taken;
  logic            timeout;
  logic [ALUOP_WIDTH-1:0] alu_sel;

  // Only the top nibble of the opcode word carries the opcode.
  logic unused_bits;
  assign unused_bits = ^{imem_data[INST_WIDTH-5:0], apsr};

  // Opcode classes; JMP/JZ/JN/JC share the 10xx pattern, C..E are undefined.
  always_comb begin
    is_jump    = (opcode_q[3:2] == 2'b10);
    is_ram     = (opcode_q != OP_NOP) && (opcode_q[3] == 1'b0);
    is_illegal = (opcode_q == 4'hC) || (opcode_q == 4'hD) || (opcode_q == 4'hE);
    case (opcode_q[1:0])
      2'd0:    jump_taken = 1'b1;
      2'd1:    jump_taken = apsr[Z_BIT];
      2'd2:    jump_taken = apsr[N_BIT];
      default: jump_taken = apsr[C_BIT];
    endcase
    // ADD..XOR (3..7) map to ALU selects 1..5; LOAD passes the operand through.
    if (opcode_q == OP_LOAD || opcode_q == OP_STORE) alu_sel = '0;
    else alu_sel = ALUOP_WIDTH'(opcode_q - 4'd2);
    timeout = !ram_ready && (wait_q == CW'(WAIT_MAX - 1));
  end

  // Datapath strobes, combinational so the datapath acts on the same edge.
  always_comb begin
    ram_req       = 1'b0;
    ram_write     = 1'b0;
    imm_update    = 1'b0;
    pc_count      = 1'b0;
    pc_load       = 1'b0;
    opcode_update = 1'b0;
    alu_operation = '0;
    acc_update    = 1'b0;
    psr_update    = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    halted        = !rst && (state_q == S_HALT);
    if (!rst && en) begin
      case (state_q)
        S_FETCH: begin
          opcode_update = 1'b1;
          pc_count      = 1'b1;
        end
        S_DECODE: begin
          if (is_illegal) illegal_op = 1'b1;
          else if (opcode_q != OP_NOP && opcode_q != OP_HALT) begin
            imm_update = 1'b1;
            pc_count   = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_jump) pc_load = jump_taken;
          else if (is_ram) begin
            ram_req = 1'b1;
            if (opcode_q == OP_STORE) ram_write = 1'b1;
            else begin
              alu_operation = alu_sel;
              acc_update    = ram_ready;
              psr_update    = ram_ready;
            end
            bus_error = timeout;
          end
        end
        default: ;
      endcase
    end
  end

  // State, latched opcode and RAM wait counter; all frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= OP_NOP;
      wait_q   <= '0;
    end else if (en) begin
      case (state_q)
        S_FETCH: begin
          opcode_q <= imem_data[INST_WIDTH-1 -: 4];
          state_q  <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode_q == OP_HALT)                      state_q <= S_HALT;
          else if (opcode_q == OP_NOP || is_illegal)    state_q <= S_FETCH;
          else                                          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_ram && !ram_ready && !timeout) begin
            wait_q <= wait_q + CW'(1);
          end else begin
            wait_q  <= '0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_ctrl_seq.sv
// tb/tb_mcu_ctrl_seq.sv - directed vector bench for mcu_ctrl_seq
module tb_mcu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst, en, ram_ready;
  logic [7:0] imem_data;
  logic [3:0] apsr;
  logic       ram_req, ram_write, imm_update, pc_count, pc_load, opcode_update;
  logic [2:0] alu_operation;
  logic       acc_update, psr_update, illegal_op, bus_error, halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcu_ctrl_seq dut (
    .clk(clk), .rst(rst), .en(en), .imem_data(imem_data), .apsr(apsr),
    .ram_ready(ram_ready), .ram_req(ram_req), .ram_write(ram_write),
    .imm_update(imm_update), .pc_count(pc_count), .pc_load(pc_load),
    .opcode_update(opcode_update), .alu_operation(alu_operation),
    .acc_update(acc_update), .psr_update(psr_update), .illegal_op(illegal_op),
    .bus_error(bus_error), .halted(halted)
  );

  // Output vector: req wr imm pcc pcl opu alu[2:0] acc psr ill berr hlt
  localparam logic [13:0] Z       = 14'h0000;
  localparam logic [13:0] FET     = 14'h0500;
  localparam logic [13:0] DEC     = 14'h0C00;
  localparam logic [13:0] REQ     = 14'h2000;
  localparam logic [13:0] LD_DONE = 14'h2018;
  localparam logic [13:0] AD_DONE = 14'h2038;
  localparam logic [13:0] SB_DONE = 14'h2058;
  localparam logic [13:0] ST_DONE = 14'h3000;
  localparam logic [13:0] PCL     = 14'h0200;
  localparam logic [13:0] ILL     = 14'h0004;
  localparam logic [13:0] BERR    = 14'h2002;
  localparam logic [13:0] HLT     = 14'h0001;

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  imem;
    logic [3:0]  apsr;
    logic        rdy;
    logic [13:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [7:0] im,
                     input logic [3:0] ps, input logic rd, input logic [13:0] ex,
                     input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.imem = im; v.apsr = ps; v.rdy = rd; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive, let strobes settle, compare, advance one cycle.
  task automatic step(input logic r, input logic e, input logic [7:0] im,
                      input logic [3:0] ps, input logic rd, input logic [13:0] ex,
                      input string nm);
    logic [13:0] act;
    rst = r; en = e; imem_data = im; apsr = ps; ram_ready = rd;
    #1;
    act = {ram_req, ram_write, imm_update, pc_count, pc_load, opcode_update,
           alu_operation, acc_update, psr_update, illegal_op, bus_error, halted};
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, ex);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; imem_data = '0; apsr = '0; ram_ready = 1'b0;

    add(1, 1, 8'h00, 4'h0, 0, Z,       "reset");
    add(1, 1, 8'h10, 4'h0, 1, Z,       "reset_rdy");
    add(0, 1, 8'h10, 4'h0, 1, FET,     "ld_fetch");
    add(0, 1, 8'hAE, 4'h0, 1, DEC,     "ld_decode");
    add(0, 1, 8'h00, 4'h0, 1, LD_DONE, "ld_exec");
    add(0, 1, 8'h30, 4'h0, 1, FET,     "add_fetch");
    add(0, 1, 8'h07, 4'h0, 1, DEC,     "add_decode");
    add(0, 1, 8'h00, 4'h0, 1, AD_DONE, "add_exec");
    add(0, 1, 8'h40, 4'h0, 1, FET,     "sub_fetch");
    add(0, 1, 8'h08, 4'h0, 1, DEC,     "sub_decode");
    add(0, 1, 8'h00, 4'h0, 1, SB_DONE, "sub_exec");
    add(0, 1, 8'h20, 4'h0, 1, FET,     "st_fetch");
    add(0, 1, 8'h09, 4'h0, 1, DEC,     "st_decode");
    add(0, 1, 8'h00, 4'h0, 1, ST_DONE, "st_exec");
    add(0, 1, 8'h90, 4'h4, 0, FET,     "jz_fetch");
    add(0, 1, 8'h05, 4'h4, 0, DEC,     "jz_decode");
    add(0, 1, 8'h00, 4'h4, 0, PCL,     "jz_taken");
    add(0, 1, 8'h90, 4'h0, 0, FET,     "jz0_fetch");
    add(0, 1, 8'h05, 4'h0, 0, DEC,     "jz0_decode");
    add(0, 1, 8'h00, 4'h0, 0, Z,       "jz_not_taken");
    add(0, 1, 8'h80, 4'h0, 0, FET,     "jmp_fetch");
    add(0, 1, 8'h05, 4'h0, 0, DEC,     "jmp_decode");
    add(0, 1, 8'h00, 4'h0, 0, PCL,     "jmp_taken");
    add(0, 1, 8'hA0, 4'h8, 0, FET,     "jn_fetch");
    add(0, 1, 8'h05, 4'h8, 0, DEC,     "jn_decode");
    add(0, 1, 8'h00, 4'h8, 0, PCL,     "jn_taken");
    add(0, 1, 8'hA0, 4'h4, 0, FET,     "jn0_fetch");
    add(0, 1, 8'h05, 4'h4, 0, DEC,     "jn0_decode");
    add(0, 1, 8'h00, 4'h4, 0, Z,       "jn_not_taken");
    add(0, 1, 8'hB0, 4'h2, 0, FET,     "jc_fetch");
    add(0, 1, 8'h05, 4'h2, 0, DEC,     "jc_decode");
    add(0, 1, 8'h00, 4'h2, 0, PCL,     "jc_taken");
    add(0, 1, 8'h00, 4'h0, 1, FET,     "nop_fetch");
    add(0, 1, 8'h55, 4'h0, 1, Z,       "nop_decode");
    add(0, 1, 8'hC0, 4'h0, 1, FET,     "ill_fetch");
    add(0, 1, 8'h55, 4'h0, 1, ILL,     "ill_decode");

    @(negedge clk);
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].en, vecs[i].imem, vecs[i].apsr, vecs[i].rdy,
           vecs[i].exp, vecs[i].name);

    // RAM timeout: 15 EXEC cycles of ram_req, bus_error on the last.
    step(0, 1, 8'h10, 4'h0, 0, FET, "to_fetch");
    step(0, 1, 8'h11, 4'h0, 0, DEC, "to_decode");
    for (int i = 0; i < 14; i++) step(0, 1, 8'h00, 4'h0, 0, REQ, "to_wait");
    step(0, 1, 8'h00, 4'h0, 0, BERR, "to_bus_error");

    // ram_ready rises after three waits.
    step(0, 1, 8'h10, 4'h0, 0, FET, "w3_fetch");
    step(0, 1, 8'h11, 4'h0, 0, DEC, "w3_decode");
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 4'h0, 0, REQ, "w3_wait");
    step(0, 1, 8'h00, 4'h0, 1, LD_DONE, "w3_done");

    // en low mid-EXEC beats ram_ready; access completes once en returns.
    step(0, 1, 8'h10, 4'h0, 1, FET, "en_fetch");
    step(0, 1, 8'h11, 4'h0, 1, DEC, "en_decode");
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 4'h0, 1, Z, "en_stall");
    step(0, 1, 8'h00, 4'h0, 1, LD_DONE, "en_resume");

    // Reset mid-EXEC abandons the access and restarts at FETCH.
    step(0, 1, 8'h10, 4'h0, 0, FET, "rx_fetch");
    step(0, 1, 8'h11, 4'h0, 0, DEC, "rx_decode");
    step(0, 1, 8'h00, 4'h0, 0, REQ, "rx_exec");
    step(1, 1, 8'h00, 4'h0, 1, Z,   "rx_reset");
    step(0, 1, 8'h00, 4'h0, 1, FET, "rx_refetch");
    step(0, 1, 8'h00, 4'h0, 1, Z,   "rx_nop_decode");

    // HALT sticks until reset, even with en low.
    step(0, 1, 8'hF0, 4'h0, 1, FET, "halt_fetch");
    step(0, 1, 8'h10, 4'h0, 1, Z,   "halt_decode");
    for (int i = 0; i < 5; i++) step(0, 1, 8'h10, 4'h0, 1, HLT, "halt_hold");
    step(0, 0, 8'h10, 4'h0, 1, HLT, "halt_en_low");
    step(1, 1, 8'h10, 4'h0, 1, Z,   "halt_reset");
    step(0, 1, 8'h10, 4'h0, 1, FET, "halt_exit_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
